// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: FSM state encoding,
// the reload-mode flag values and a small state helper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // A timer counts as active from load until its expiry is consumed or cancelled.
    function automatic logic is_active(input state_t s);
        return (s == RUN) || (s == DONE);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Request/response and control bundle of the countdown timer.
// The master side issues count requests and consumes expiries; the slave side is the timer.
interface countdown_timer_if #(
    parameter int bitwidth = 32
);
    logic                req_val;
    logic                req_rdy;
    logic [bitwidth-1:0] req_count;
    logic                req_periodic;
    logic                hold;
    logic                cancel;
    logic                resp_val;
    logic                resp_rdy;
    logic                busy;
    logic [bitwidth-1:0] count_out;

    modport master (
        output req_val, req_count, req_periodic, hold, cancel, resp_rdy,
        input  req_rdy, resp_val, busy, count_out
    );

    modport slave (
        input  req_val, req_count, req_periodic, hold, cancel, resp_rdy,
        output req_rdy, resp_val, busy, count_out
    );
endinterface

// File: rtl/countdown_timer_counter.sv
// Loadable down-counter without reset: LD has priority over EN and the
// value saturates at zero instead of wrapping.
module counter #(
    parameter int bitwidth = 32
) (
    input  logic                CLK,
    input  logic                LD,
    input  logic                EN,
    input  logic [bitwidth-1:0] IN,
    output logic [bitwidth-1:0] OUT
);
    localparam logic [bitwidth-1:0] ONE = bitwidth'(1);

    always_ff @(posedge CLK) begin
        if (LD) begin
            OUT <= IN;
        end else if (EN && (OUT != '0)) begin
            OUT <= OUT - ONE;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// One-shot / periodic interval timer: a val/rdy front-end that loads the
// down-counter, watches it reach zero and holds an expiry response until consumed.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int bitwidth = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    countdown_timer_if.slave tif
);
    state_t              state_reg, state_next;
    logic [bitwidth-1:0] period_reg, period_next;
    logic                periodic_reg, periodic_next;

    logic                ld;
    logic                en;
    logic [bitwidth-1:0] load_value;
    logic [bitwidth-1:0] cnt;
    logic                cnt_zero;
    logic                accept;
    logic                resp_fire;

    counter #(
        .bitwidth(bitwidth)
    ) u_counter (
        .CLK(CLK),
        .LD (ld),
        .EN (en),
        .IN (load_value),
        .OUT(cnt)
    );

    // All handshake outputs are forced inactive while RESET is high.
    assign tif.req_rdy   = (state_reg == IDLE) && !RESET;
    assign tif.resp_val  = (state_reg == DONE) && !RESET;
    assign tif.busy      = is_active(state_reg) && !RESET;
    // The counter is undefined before its first load, so never expose it in IDLE.
    assign tif.count_out = tif.busy ? cnt : '0;

    assign cnt_zero  = (cnt == '0);
    assign accept    = tif.req_val && tif.req_rdy;
    assign resp_fire = tif.resp_val && tif.resp_rdy;

    always_comb begin
        state_next    = state_reg;
        period_next   = period_reg;
        periodic_next = periodic_reg;
        ld            = 1'b0;
        en            = 1'b0;
        load_value    = period_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    ld            = 1'b1;
                    load_value    = tif.req_count;
                    period_next   = tif.req_count;
                    periodic_next = tif.req_periodic;
                    state_next    = RUN;
                end
            end
            RUN: begin
                if (tif.cancel) begin
                    state_next = IDLE;
                end else if (cnt_zero) begin
                    state_next = DONE;
                end else begin
                    en = !tif.hold;
                end
            end
            DONE: begin
                // cancel wins over a coincident handshake: the expiry is dropped.
                if (tif.cancel) begin
                    state_next = IDLE;
                end else if (resp_fire) begin
                    if (periodic_reg == MODE_PERIODIC) begin
                        ld         = 1'b1;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg    <= IDLE;
            period_reg   <= '0;
            periodic_reg <= MODE_ONESHOT;
        end else begin
            state_reg    <= state_next;
            period_reg   <= period_next;
            periodic_reg <= periodic_next;
        end
    end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Val/rdy front-end that owns the team's `counter` down-counter and turns it into a one-shot or periodic interval timer.
- Accepts a count request and drives the counter's LD, EN and IN controls.
- Watches the counter's OUT reaching zero and issues a val/rdy expiry response downstream.
- Used wherever a block needs "wait N cycles, then notify", e.g. sample-interval and timeout generation.

Parameters:
- bitwidth, 32, width of the count and of the internal counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous reset, active-high.
- req_val  input  1  request valid.
- req_rdy  output  1  request ready; high only in IDLE.
- req_count  input  bitwidth  number of decrement cycles N.
- req_periodic  input  1  1 = auto-reload after each expiry; 0 = one-shot.
- hold  input  1  pauses decrementing while high.
- cancel  input  1  aborts the active timer.
- resp_val  output  1  expiry response valid.
- resp_rdy  input  1  expiry consumer ready.
- busy  output  1  high in RUN or DONE.
- count_out  output  bitwidth  current counter value in RUN/DONE; 0 in IDLE.

Behaviour:
- States: IDLE, RUN, DONE. RESET (sampled on the edge) forces IDLE and clears the period register and periodic flag.
- Outputs while RESET is high or in IDLE: req_rdy = 1 in IDLE, 0 while RESET is high; resp_val = 0; busy = 0; count_out = 0.
- The counter has no reset, so its value is undefined until the first load. The controller must never consume OUT in IDLE, and count_out is masked to 0 in IDLE.
- IDLE, req_val && req_rdy in cycle t:
  - counter LD = 1 with IN = req_count;
  - req_count is latched into the period register and req_periodic into the periodic flag;
  - next state RUN, with counter = N at t+1.
- RUN:
  - Counter EN = !hold && (OUT != 0).
  - When OUT == 0 (and not cancelled), next state is DONE.
  - The counter never decrements past 0, so there is no wrap-around.
  - Expiry latency with hold low: resp_val first asserted at cycle t+N+2. N = 0 gives t+2.
  - Each cycle hold is high in RUN adds exactly one cycle. hold has no effect in IDLE or DONE.
- DONE:
  - resp_val = 1; counter is idle (LD = 0, EN = 0) and OUT stays 0.
  - On resp_val && resp_rdy with periodic flag = 1: LD = 1 with IN = period register, next state RUN. Successive responses are therefore N+2 cycles apart when resp_rdy is held high.
  - On resp_val && resp_rdy with periodic flag = 0: next state IDLE.
  - Without resp_rdy, stay in DONE with resp_val held (no drop, no overrun).
- cancel:
  - In RUN or DONE: next state IDLE. No response is issued, even if resp_val and resp_rdy coincide with cancel in that cycle, i.e. cancel has priority over the handshake.
  - In IDLE: ignored. A same-cycle req_val is still accepted.
- Priority in RUN/DONE: RESET > cancel > handshake/expiry > hold.
- Reset mid-operation: IDLE on the next edge. Counter contents are don't-care; the next request reloads them.
- Widths: req_count and the period register are bitwidth unsigned. Max N = 2^bitwidth − 1, no saturation logic needed.

Decomposition:
- Package timer_pkg:
  - state typedef (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - mode constants MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1.
- One sub-module: the existing `counter`, instantiated with bitwidth passed through. Its LD/EN/IN are driven by the combinational control of this block; its OUT is observed.
- FSM, period register and periodic flag live in countdown_timer.

Test Plan:
- Reset then one-shot: RESET 2 cycles; req_count = 3, req_periodic = 0 accepted at t, resp_rdy = 1 → count_out 3, 2, 1, 0 at t+1..t+4; resp_val at t+5 for 1 cycle; req_rdy = 1 at t+6.
- N = 0: accept req_count = 0 at t → resp_val at t+2; one-shot returns to IDLE at t+3.
- Periodic with backpressure: N = 2, periodic. resp_rdy = 0 for 4 cycles after the first expiry → resp_val stays high and count_out stays 0. Then resp_rdy = 1 → next resp_val 4 cycles after that handshake; repeats until cancel.
- hold: N = 5, hold high for 3 cycles during RUN → resp_val at t+10 instead of t+7; count_out is frozen during hold.
- cancel: cancel in RUN with count_out = 2 → IDLE next cycle, no resp_val ever. cancel asserted with resp_val && resp_rdy in DONE → IDLE and the response is not counted. cancel with req_val in IDLE → request accepted.
- Mid-run reset: RESET while count_out = 7 → next cycle req_rdy = 0 while RESET is high, then 1; busy = 0, count_out = 0. A fresh req_count = 1 then expires at +3.
